// File: rtl/ctx_switch_ctrl.sv
// Interrupt context save/restore sequencer for the user/L1/L2 shadow banks; strobe 1 cycle and ack 2 cycles after request when wb_busy=0.
// Stalls and blocks register writes during a switch; define CTX_ERR_CNT_EN to add the saturating err_count output.
module ctx_switch_ctrl #(
    parameter int DRAIN_TIMEOUT = 8,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_enter,
    input  logic       int_exit,
    input  logic       wb_busy,
    output logic       enable_userBackUp,
    output logic       enable_BackUp1,
    output logic       enable_BackUp2,
    output logic       restore_userBackUp,
    output logic       restore_BackUp1,
    output logic       restore_BackUp2,
    output logic       stall,
    output logic       we_block,
    output logic       ack_enter,
    output logic       ack_exit,
    output logic       err_nest,
    output logic [1:0] depth,
    output logic       drain_to
`ifdef CTX_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        SAVE    = 3'd2,
        RESTORE = 3'd3,
        ACK     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [1:0]         depth_q, depth_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_is_exit_q, op_is_exit_d;
    logic               err_q, err_d;
    logic               dto_q, dto_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            depth_q      <= 2'd0;
            cnt_q        <= '0;
            op_is_exit_q <= 1'b0;
            err_q        <= 1'b0;
            dto_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            cnt_q        <= cnt_d;
            op_is_exit_q <= op_is_exit_d;
            err_q        <= err_d;
            dto_q        <= dto_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        depth_d            = depth_q;
        cnt_d              = '0;
        op_is_exit_d       = op_is_exit_q;
        err_d              = 1'b0;
        dto_d              = dto_q;
        enable_userBackUp  = 1'b0;
        enable_BackUp1     = 1'b0;
        restore_userBackUp = 1'b0;
        restore_BackUp1    = 1'b0;
        stall              = 1'b0;
        we_block           = 1'b0;
        ack_enter          = 1'b0;
        ack_exit           = 1'b0;

        case (state_q)
            IDLE: begin
                // The request is still held during the err pulse cycle; ignore it then.
                if (!err_q) begin
                    if (int_exit) begin
                        if (depth_q == 2'd0) begin
                            err_d = 1'b1;
                        end else begin
                            op_is_exit_d = 1'b1;
                            state_d      = wb_busy ? DRAIN : RESTORE;
                        end
                    end else if (int_enter) begin
                        if (depth_q == 2'd2) begin
                            err_d = 1'b1;
                        end else begin
                            op_is_exit_d = 1'b0;
                            state_d      = wb_busy ? DRAIN : SAVE;
                        end
                    end
                end
            end
            DRAIN: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (!wb_busy) begin
                    cnt_d   = '0;
                    state_d = op_is_exit_q ? RESTORE : SAVE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    dto_d   = 1'b1;
                    state_d = op_is_exit_q ? RESTORE : SAVE;
                end
            end
            SAVE: begin
                stall    = 1'b1;
                we_block = 1'b1;
                if (depth_q == 2'd0) begin
                    enable_userBackUp = 1'b1;
                end else if (depth_q == 2'd1) begin
                    enable_BackUp1 = 1'b1;
                end
                if (depth_q != 2'd2) begin
                    depth_d = depth_q + 2'd1;
                end
                state_d = ACK;
            end
            RESTORE: begin
                stall    = 1'b1;
                we_block = 1'b1;
                if (depth_q == 2'd2) begin
                    restore_BackUp1 = 1'b1;
                end else if (depth_q == 2'd1) begin
                    restore_userBackUp = 1'b1;
                end
                if (depth_q != 2'd0) begin
                    depth_d = depth_q - 2'd1;
                end
                state_d = ACK;
            end
            ACK: begin
                stall     = 1'b1;
                ack_enter = !op_is_exit_q;
                ack_exit  = op_is_exit_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign enable_BackUp2  = 1'b0;
    assign restore_BackUp2 = 1'b0;
    assign err_nest        = err_q;
    assign depth           = depth_q;
    assign drain_to        = dto_q;

`ifdef CTX_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       tmo_evt;

    // Leaving DRAIN while wb_busy is still high can only be a timeout.
    assign tmo_evt = (state_q == DRAIN) && (state_d != DRAIN) && wb_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if ((err_d || tmo_evt) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: doc/ctx_switch_ctrl.md
Name: ctx_switch_ctrl

Overview:
Sequences interrupt context save and restore for the register file's three shadow banks (user, level-1, level-2). Tracks interrupt nesting depth 0..2 and converts enter/exit requests into single-cycle backup and restore strobes at a safe point. Stalls the pipeline and blocks register writes while a switch is in progress. Sits between the interrupt/eret logic in the control unit and the register file.

Parameters:
DRAIN_TIMEOUT, 8, max cycles to wait in DRAIN for wb_busy to fall before forcing the switch
CNT_W, 4, width of the drain counter; must satisfy 2^CNT_W > DRAIN_TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
int_enter  in  1  level request: enter ISR, save context; held until ack_enter or err_nest
int_exit  in  1  level request: eret, restore context; held until ack_exit or err_nest
wb_busy  in  1  pipeline has an in-flight register write
enable_userBackUp  out  1  strobe: copy live regs to user bank
enable_BackUp1  out  1  strobe: copy live regs to bank 1
enable_BackUp2  out  1  strobe: copy live regs to bank 2 (reserved, never asserted)
restore_userBackUp  out  1  strobe: load live regs from user bank
restore_BackUp1  out  1  strobe: load live regs from bank 1
restore_BackUp2  out  1  strobe: load live regs from bank 2 (reserved, never asserted)
stall  out  1  freeze the pipeline front end
we_block  out  1  gate the register file WE
ack_enter  out  1  one-cycle pulse: save complete
ack_exit  out  1  one-cycle pulse: restore complete
err_nest  out  1  one-cycle pulse: request refused (overflow or underflow)
depth  out  2  current nesting depth, 0..2
drain_to  out  1  sticky: a drain timeout has occurred since reset

Behaviour:
- Reset: state IDLE; depth=0; drain counter=0; every strobe, ack, err, stall, we_block and drain_to = 0. A reset during any state aborts the operation with no strobe, and depth returns to 0. Bank contents are not touched.
- States: IDLE, DRAIN, SAVE, RESTORE, ACK. Registered flag op_is_exit records the operation in progress.
- IDLE:
  - int_exit takes priority over int_enter when both are high.
  - Exit with depth=0, or enter with depth=2: pulse err_nest next cycle, stay in IDLE, depth unchanged.
  - Otherwise latch op_is_exit. Go to DRAIN if wb_busy=1, else straight to SAVE (enter) or RESTORE (exit).
- DRAIN:
  - stall=1. Counter increments each cycle.
  - When wb_busy=0, go to SAVE or RESTORE.
  - When counter reaches DRAIN_TIMEOUT, go to SAVE or RESTORE anyway and set drain_to.
  - Counter clears on leaving DRAIN.
- SAVE (one cycle):
  - stall=1, we_block=1.
  - Assert exactly one strobe: enable_userBackUp if depth=0, enable_BackUp1 if depth=1.
  - depth increments at the end of the cycle; go to ACK.
- RESTORE (one cycle):
  - stall=1, we_block=1.
  - Assert restore_BackUp1 if depth=2, restore_userBackUp if depth=1.
  - depth decrements; go to ACK.
- ACK: stall=1. Pulse ack_enter or ack_exit per op_is_exit; go to IDLE.
- IDLE does not re-sample requests until the cycle after ACK. Requesters must drop their request on the edge after the ack or err pulse.
- Latency with wb_busy=0: request seen in cycle 0, strobe in cycle 1, ack in cycle 2, IDLE in cycle 3.
- Invariants:
  - Strobes are mutually exclusive.
  - No strobe is ever asserted outside SAVE or RESTORE.
  - stall=0 only in IDLE.
  - depth never leaves the range 0..2.

Optional Feature:
Macro CTX_ERR_CNT_EN.
- Defined: adds output err_count[7:0], reset 0. Increments on every err_nest pulse and on every drain timeout event, and saturates at 255.
- Undefined: the port and the counter are absent. err_nest and drain_to behave identically in both builds.

Test Plan:
- rst, then int_enter=1, wb_busy=0 → enable_userBackUp high in cycle 1 only, ack_enter in cycle 2, depth=1, stall high in cycles 1-2.
- From depth=1, int_enter → enable_BackUp1 pulse, depth=2. A further int_enter → err_nest pulse, no strobe, depth stays 2.
- From depth=2, int_exit → restore_BackUp1. A second int_exit → restore_userBackUp, depth=0. A third int_exit → err_nest.
- int_enter with wb_busy high for 3 cycles → DRAIN for 3 cycles, strobe on the 4th cycle, drain_to stays 0.
- wb_busy stuck high with DRAIN_TIMEOUT=8 → strobe after the timeout, drain_to=1 (and err_count=1 with CTX_ERR_CNT_EN).
- int_enter and int_exit together at depth=1 → restore_userBackUp, not a save. rst asserted during DRAIN → no strobe, depth=0, all outputs 0.
